vout_layer_sched: RTL and testbench
===================================

Name: vout_layer_sched

Overview:
- Per-pixel window scheduler for the quad-layer display path.
- Tracks the active-pixel x/y position from the timing generator's hs/vs/de.
- For each of 4 video layers (quad CVBS inputs), decides whether the current pixel falls in that layer's window and raises that layer's FIFO read request.
- Reports the topmost visible layer and its alpha to the downstream alpha-mix/YCbCr-to-RGB stage, with sync delayed to match.
- Layer geometry is shadowed and swapped only at frame start, so the picture never tears.

Parameters:
- VS_POL, 1, active level of i_vs (1 = active-high, 0 = active-low).
- BG_ALPHA, 8'h00, alpha reported when no layer covers the pixel.

Ports:
- dp_clk  in  1  pixel clock.
- rst  in  1  asynchronous reset, active-high.
- i_hs  in  1  horizontal sync from the timing generator.
- i_vs  in  1  vertical sync from the timing generator.
- i_de  in  1  data enable from the timing generator.
- layer_en  in  4  per-layer enable; bit i = layer i.
- layer_top  in  48  12 bits per layer; [12i+11:12i] = layer i.
- layer_left  in  48  same packing as layer_top.
- layer_width  in  48  same packing as layer_top.
- layer_height  in  48  same packing as layer_top.
- layer_alpha  in  32  8 bits per layer; [8i+7:8i] = layer i.
- cfg_update  in  1  one-cycle pulse: apply current config at next frame start.
- layer_rdreq  out  4  per-layer FIFO read request.
- o_hs  out  1  i_hs delayed by 2 cycles.
- o_vs  out  1  i_vs delayed by 2 cycles.
- o_de  out  1  i_de delayed by 2 cycles.
- o_sel  out  3  selected layer 0..3; 4 = background.
- o_alpha  out  8  alpha of the selected layer.
- o_x  out  12  pixel x aligned with o_de.
- o_y  out  12  pixel y aligned with o_de.
- cfg_applied  out  1  one-cycle pulse when the shadow config is loaded.

Behaviour:
- Reset values:
  - All outputs 0, except o_sel = 4 and o_alpha = BG_ALPHA.
  - x_cnt = 0, y_cnt = 0, pending = 0.
  - All shadow registers 0; layer_en shadow = 0, so nothing is visible until the first apply.
- Frame start: a registered edge detect of i_vs going to its active level (VS_POL) marks frame start.
- x_cnt: increments on every cycle with i_de = 1; clears to 0 on the cycle after i_de falls.
- y_cnt: increments when i_de falls; clears to 0 at frame start. Frame start takes priority over the de-fall increment in the same cycle.
- Counter overflow: both counters saturate at 4095; no wrap-around.
- Config pending:
  - cfg_update sets pending.
  - At frame start with pending = 1: load all layer_* inputs into the shadow registers, clear pending, and pulse cfg_applied for 1 cycle.
  - If cfg_update and frame start coincide, apply immediately, sampling the inputs that cycle; pending ends at 0.
  - If cfg_update pulses again while pending, there is no extra effect.
- Window test (combinational, uses shadow values and the current x_cnt/y_cnt):
  - in_i = en_i & (x >= left_i) & (x < left_i + width_i) & (y >= top_i) & (y < top_i + height_i).
  - Sums are computed at 13 bits, so left + width > 4095 never wraps.
  - width = 0 or height = 0 means the layer is never inside.
- Read requests: layer_rdreq[i] = i_de & in_i, in the same cycle as i_de (zero latency), so the FIFO data is valid 1 cycle later.
- Priority: a higher index wins, so layer 3 is on top. Every covering layer still gets its rdreq, so each FIFO drains per its own window.
- Output pipeline:
  - Stage 1 registers sel/alpha/x/y.
  - Stage 2 registers them again into o_sel, o_alpha, o_x, o_y, together with o_hs/o_vs/o_de.
  - Total latency is 2 cycles.
  - When the stage-2 de = 0: o_sel = 4 and o_alpha = BG_ALPHA.
- Reset mid-frame: everything returns to reset values immediately, and the counters restart. Output stays at background until the next frame start and a cfg_update.

Optional Feature:
- Macro: LAYER_BORDER_EN.
- Defined:
  - Adds output o_border (1 bit), aligned with o_de.
  - o_border = 1 when the pixel lies on the first or last column or row of the selected layer's window: x == left, x == left+width-1, y == top, or y == top+height-1.
  - While o_border = 1, o_alpha is forced to 8'hFF.
  - Reset value of o_border is 0.
- Undefined: no o_border port; o_alpha is unaffected.

Test Plan:
- Reset, then 640x480 timing with no cfg_update: layer_rdreq stays 0, o_sel = 4 throughout, o_alpha = BG_ALPHA.
- Layer0 at top=10, left=20, width=100, height=50, alpha=8'h80, plus cfg_update:
  - Next frame, rdreq[0] high for exactly x 20..119 on lines 10..59, giving 5000 requests in total.
  - o_sel = 0 and o_alpha = 8'h80 two cycles after each rdreq.
- Overlap: layer0 at (0,0,320,240) and layer3 at (100,100,320,240), both enabled:
  - At x=150, y=150 both rdreq bits are high, o_sel = 3, o_alpha = layer3 alpha.
  - At x=50, y=50, o_sel = 0.
- Change the layer0 left value mid-frame and pulse cfg_update:
  - Current frame windows are unchanged.
  - cfg_applied pulses once at the next vs edge and the new window takes effect in that frame.
  - cfg_update coincident with the vs edge applies the same cycle.
- Boundary: left=4000, width=200 gives rdreq for x 4000..4095 with no wrap to x 0..103; width=0 gives no rdreq at all.
- Assert rst mid-line: all outputs reach reset values asynchronously; after release there is no rdreq until frame start plus a cfg_update.

Source files
------------

// File: rtl/vout_layer_sched_if.sv
// Interface bundling the timing input, layer configuration and mixed-output
// signals of vout_layer_sched. The slave modport is the scheduler's view; the
// master modport is the view of whatever drives timing/config and consumes
// the scheduled stream.
// Optional macro LAYER_BORDER_EN adds the o_border output.
interface vout_layer_sched_if;
    logic        i_hs;
    logic        i_vs;
    logic        i_de;
    logic [3:0]  layer_en;
    logic [47:0] layer_top;
    logic [47:0] layer_left;
    logic [47:0] layer_width;
    logic [47:0] layer_height;
    logic [31:0] layer_alpha;
    logic        cfg_update;
    logic [3:0]  layer_rdreq;
    logic        o_hs;
    logic        o_vs;
    logic        o_de;
    logic [2:0]  o_sel;
    logic [7:0]  o_alpha;
    logic [11:0] o_x;
    logic [11:0] o_y;
    logic        cfg_applied;
`ifdef LAYER_BORDER_EN
    logic        o_border;
`endif

    modport master (
        output i_hs, i_vs, i_de, layer_en, layer_top, layer_left, layer_width,
               layer_height, layer_alpha, cfg_update,
        input  layer_rdreq, o_hs, o_vs, o_de, o_sel, o_alpha, o_x, o_y, cfg_applied
`ifdef LAYER_BORDER_EN
        , o_border
`endif
    );

    modport slave (
        input  i_hs, i_vs, i_de, layer_en, layer_top, layer_left, layer_width,
               layer_height, layer_alpha, cfg_update,
        output layer_rdreq, o_hs, o_vs, o_de, o_sel, o_alpha, o_x, o_y, cfg_applied
`ifdef LAYER_BORDER_EN
        , o_border
`endif
    );
endinterface

// File: rtl/vout_layer_sched.sv
// Per-pixel window scheduler for the quad-layer display path.
// Tracks the active x/y position, raises each layer's FIFO read request while
// the pixel is inside that layer's window, and reports the topmost layer and
// its alpha two cycles later alongside the delayed syncs. Layer geometry is
// shadowed and only swapped at frame start so a frame never tears.
// Optional macro LAYER_BORDER_EN: adds o_border and forces alpha to 8'hFF on
// the outline of the selected layer's window.
module vout_layer_sched #(
    parameter logic       VS_POL   = 1'b1,
    parameter logic [7:0] BG_ALPHA = 8'h00
) (
    input logic               dp_clk,
    input logic               rst,
    vout_layer_sched_if.slave bus
);
    localparam int          NL      = 4;
    localparam logic [2:0]  SEL_BG  = 3'd4;
    localparam logic [11:0] CNT_MAX = 12'hFFF;

    logic        vs_act;
    logic        vs_act_reg;
    logic        de_reg;
    logic        frame_start;
    logic        de_fall;
    logic        load_cfg;
    logic [11:0] x_cnt_reg;
    logic [11:0] y_cnt_reg;
    logic        pending_reg;
    logic        applied_reg;

    logic [3:0]  sh_en_reg;
    logic [11:0] sh_top_reg    [NL];
    logic [11:0] sh_left_reg   [NL];
    logic [11:0] sh_width_reg  [NL];
    logic [11:0] sh_height_reg [NL];
    logic [7:0]  sh_alpha_reg  [NL];

    logic [3:0]  in_win;
    logic [12:0] x_ext;
    logic [12:0] y_ext;
    logic [2:0]  sel_next;
    logic [7:0]  alpha_next;

    logic        s1_hs_reg, s1_vs_reg, s1_de_reg;
    logic [2:0]  s1_sel_reg;
    logic [7:0]  s1_alpha_reg;
    logic [11:0] s1_x_reg, s1_y_reg;

    logic        o_hs_reg, o_vs_reg, o_de_reg;
    logic [2:0]  o_sel_reg;
    logic [7:0]  o_alpha_reg;
    logic [11:0] o_x_reg, o_y_reg;

`ifdef LAYER_BORDER_EN
    logic [3:0]  on_edge;
    logic        border_next;
    logic        s1_border_reg;
    logic        o_border_reg;
`endif

    assign vs_act      = (bus.i_vs == VS_POL);
    assign frame_start = vs_act & ~vs_act_reg;
    assign de_fall     = de_reg & ~bus.i_de;
    // A coincident cfg_update applies immediately, sampling this cycle's inputs.
    assign load_cfg    = frame_start & (pending_reg | bus.cfg_update);
    assign x_ext       = {1'b0, x_cnt_reg};
    assign y_ext       = {1'b0, y_cnt_reg};

    // History of vs/de used for the frame-start and line-end edge detects.
    always_ff @(posedge dp_clk or posedge rst) begin
        if (rst) begin
            vs_act_reg <= 1'b0;
            de_reg     <= 1'b0;
        end else begin
            vs_act_reg <= vs_act;
            de_reg     <= bus.i_de;
        end
    end

    // Pixel position counters, saturating at 4095 instead of wrapping.
    always_ff @(posedge dp_clk or posedge rst) begin
        if (rst) begin
            x_cnt_reg <= '0;
            y_cnt_reg <= '0;
        end else begin
            if (bus.i_de) begin
                if (x_cnt_reg != CNT_MAX) x_cnt_reg <= x_cnt_reg + 12'd1;
            end else if (de_fall) begin
                x_cnt_reg <= '0;
            end
            if (frame_start) begin
                y_cnt_reg <= '0;
            end else if (de_fall && (y_cnt_reg != CNT_MAX)) begin
                y_cnt_reg <= y_cnt_reg + 12'd1;
            end
        end
    end

    // Pending-update flag and the one-cycle applied pulse.
    always_ff @(posedge dp_clk or posedge rst) begin
        if (rst) begin
            pending_reg <= 1'b0;
            applied_reg <= 1'b0;
        end else begin
            applied_reg <= load_cfg;
            if (load_cfg) begin
                pending_reg <= 1'b0;
            end else if (bus.cfg_update) begin
                pending_reg <= 1'b1;
            end
        end
    end

    // Shadow copy of the layer geometry, swapped only at frame start.
    always_ff @(posedge dp_clk or posedge rst) begin
        if (rst) begin
            sh_en_reg <= '0;
            for (int i = 0; i < NL; i++) begin
                sh_top_reg[i]    <= '0;
                sh_left_reg[i]   <= '0;
                sh_width_reg[i]  <= '0;
                sh_height_reg[i] <= '0;
                sh_alpha_reg[i]  <= '0;
            end
        end else if (load_cfg) begin
            sh_en_reg <= bus.layer_en;
            for (int i = 0; i < NL; i++) begin
                sh_top_reg[i]    <= bus.layer_top[12*i +: 12];
                sh_left_reg[i]   <= bus.layer_left[12*i +: 12];
                sh_width_reg[i]  <= bus.layer_width[12*i +: 12];
                sh_height_reg[i] <= bus.layer_height[12*i +: 12];
                sh_alpha_reg[i]  <= bus.layer_alpha[8*i +: 8];
            end
        end
    end

    // Window test per layer; 13-bit end coordinates so left+width never wraps.
    for (genvar gi = 0; gi < NL; gi++) begin : g_win
        logic [12:0] x_end;
        logic [12:0] y_end;
        assign x_end = {1'b0, sh_left_reg[gi]} + {1'b0, sh_width_reg[gi]};
        assign y_end = {1'b0, sh_top_reg[gi]} + {1'b0, sh_height_reg[gi]};
        assign in_win[gi] = sh_en_reg[gi]
                          & (x_ext >= {1'b0, sh_left_reg[gi]}) & (x_ext < x_end)
                          & (y_ext >= {1'b0, sh_top_reg[gi]})  & (y_ext < y_end);
`ifdef LAYER_BORDER_EN
        assign on_edge[gi] = (x_ext == {1'b0, sh_left_reg[gi]}) | (x_ext == x_end - 13'd1)
                           | (y_ext == {1'b0, sh_top_reg[gi]})  | (y_ext == y_end - 13'd1);
`endif
    end

    // Every covering layer drains its own FIFO, with no added latency.
    assign bus.layer_rdreq = {NL{bus.i_de}} & in_win;

    // Priority select: later (higher-index) layers overwrite, so layer 3 is on top.
    always_comb begin
        sel_next   = SEL_BG;
        alpha_next = BG_ALPHA;
`ifdef LAYER_BORDER_EN
        border_next = 1'b0;
`endif
        for (int i = 0; i < NL; i++) begin
            if (in_win[i]) begin
                sel_next   = 3'(i);
                alpha_next = sh_alpha_reg[i];
`ifdef LAYER_BORDER_EN
                border_next = on_edge[i];
`endif
            end
        end
    end

    // Stage 1: capture selection, position and syncs for the current pixel.
    always_ff @(posedge dp_clk or posedge rst) begin
        if (rst) begin
            s1_hs_reg    <= 1'b0;
            s1_vs_reg    <= 1'b0;
            s1_de_reg    <= 1'b0;
            s1_sel_reg   <= SEL_BG;
            s1_alpha_reg <= BG_ALPHA;
            s1_x_reg     <= '0;
            s1_y_reg     <= '0;
`ifdef LAYER_BORDER_EN
            s1_border_reg <= 1'b0;
`endif
        end else begin
            s1_hs_reg    <= bus.i_hs;
            s1_vs_reg    <= bus.i_vs;
            s1_de_reg    <= bus.i_de;
            s1_sel_reg   <= sel_next;
            s1_alpha_reg <= alpha_next;
            s1_x_reg     <= x_cnt_reg;
            s1_y_reg     <= y_cnt_reg;
`ifdef LAYER_BORDER_EN
            s1_border_reg <= border_next;
`endif
        end
    end

    // Stage 2: output registers; blanking always reports background.
    always_ff @(posedge dp_clk or posedge rst) begin
        if (rst) begin
            o_hs_reg    <= 1'b0;
            o_vs_reg    <= 1'b0;
            o_de_reg    <= 1'b0;
            o_sel_reg   <= SEL_BG;
            o_alpha_reg <= BG_ALPHA;
            o_x_reg     <= '0;
            o_y_reg     <= '0;
`ifdef LAYER_BORDER_EN
            o_border_reg <= 1'b0;
`endif
        end else begin
            o_hs_reg <= s1_hs_reg;
            o_vs_reg <= s1_vs_reg;
            o_de_reg <= s1_de_reg;
            o_x_reg  <= s1_x_reg;
            o_y_reg  <= s1_y_reg;
            o_sel_reg <= s1_de_reg ? s1_sel_reg : SEL_BG;
`ifdef LAYER_BORDER_EN
            o_border_reg <= s1_de_reg & s1_border_reg;
            if (!s1_de_reg)         o_alpha_reg <= BG_ALPHA;
            else if (s1_border_reg) o_alpha_reg <= 8'hFF;
            else                    o_alpha_reg <= s1_alpha_reg;
`else
            o_alpha_reg <= s1_de_reg ? s1_alpha_reg : BG_ALPHA;
`endif
        end
    end

    assign bus.o_hs        = o_hs_reg;
    assign bus.o_vs        = o_vs_reg;
    assign bus.o_de        = o_de_reg;
    assign bus.o_sel       = o_sel_reg;
    assign bus.o_alpha     = o_alpha_reg;
    assign bus.o_x         = o_x_reg;
    assign bus.o_y         = o_y_reg;
    assign bus.cfg_applied = applied_reg;
`ifdef LAYER_BORDER_EN
    assign bus.o_border    = o_border_reg;
`endif
endmodule

// File: tb/tb_vout_layer_sched.sv
// Self-checking bench for vout_layer_sched: a bench-side timing generator and
// window model push expected pixels into a scoreboard queue that is popped as
// the two-cycle output pipeline delivers them. Frame sizes are reduced to keep
// the run short. Honors LAYER_BORDER_EN when defined.
module tb_vout_layer_sched;
    localparam logic [7:0] BG = 8'h5A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vout_layer_sched_if bus ();

    vout_layer_sched #(.VS_POL(1'b1), .BG_ALPHA(BG)) dut (
        .dp_clk (clk),
        .rst    (rst),
        .bus    (bus)
    );

    typedef struct {
        bit de; bit hs; bit vs;
        int sel; int alpha; int x; int y;
        bit xy; bit border;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    int cfg_en[4], cfg_top[4], cfg_left[4], cfg_w[4], cfg_h[4], cfg_a[4];
    int sh_en[4], sh_top[4], sh_left[4], sh_w[4], sh_h[4], sh_a[4];
    bit m_pend, m_vs_prev, m_app_now, xy_valid;

    int rd_cnt[4];
    int sel_cnt[5];
    int app_cnt;
    int first_col;
    logic [3:0] obs_rd_a;
    logic [2:0] obs_sel_a, obs_sel_b;
    logic [7:0] obs_alpha_a;

    task automatic clear_cfg();
        for (int i = 0; i < 4; i++) begin
            cfg_en[i] = 0; cfg_top[i] = 0; cfg_left[i] = 0;
            cfg_w[i] = 0; cfg_h[i] = 0; cfg_a[i] = 0;
        end
    endtask

    task automatic set_layer(input int i, input int top, input int left,
                             input int w, input int h, input int a);
        cfg_en[i] = 1; cfg_top[i] = top; cfg_left[i] = left;
        cfg_w[i] = w; cfg_h[i] = h; cfg_a[i] = a;
    endtask

    task automatic drive_pins();
        for (int i = 0; i < 4; i++) begin
            bus.layer_en[i]             = (cfg_en[i] != 0);
            bus.layer_top[12*i +: 12]    = 12'(cfg_top[i]);
            bus.layer_left[12*i +: 12]   = 12'(cfg_left[i]);
            bus.layer_width[12*i +: 12]  = 12'(cfg_w[i]);
            bus.layer_height[12*i +: 12] = 12'(cfg_h[i]);
            bus.layer_alpha[8*i +: 8]    = 8'(cfg_a[i]);
        end
    endtask

    function automatic bit win(input int i, input int x, input int y);
        return sh_en[i] != 0 && x >= sh_left[i] && x < sh_left[i] + sh_w[i]
            && y >= sh_top[i] && y < sh_top[i] + sh_h[i];
    endfunction

    function automatic bit edge_of(input int i, input int x, input int y);
        return x == sh_left[i] || x == sh_left[i] + sh_w[i] - 1
            || y == sh_top[i]  || y == sh_top[i] + sh_h[i] - 1;
    endfunction

    task automatic model_reset();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            sh_en[i] = 0; sh_top[i] = 0; sh_left[i] = 0;
            sh_w[i] = 0; sh_h[i] = 0; sh_a[i] = 0;
        end
        m_pend = 0; m_vs_prev = 0; m_app_now = 0; xy_valid = 0;
        exp_q.delete();
        e.de = 0; e.hs = 0; e.vs = 0; e.sel = 4; e.alpha = BG;
        e.x = 0; e.y = 0; e.xy = 0; e.border = 0;
        exp_q.push_back(e);
        exp_q.push_back(e);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) rd_cnt[i] = 0;
        for (int i = 0; i < 5; i++) sel_cnt[i] = 0;
        app_cnt = 0;
        first_col = -1;
    endtask

    // One pixel clock: drive inputs, advance the model, check rdreq/applied,
    // and pop one scoreboard entry against the pipelined outputs.
    task automatic drive_cycle(input bit hs, input bit vs, input bit de,
                               input int col, input int row, input bit upd);
        exp_t e;
        exp_t h;
        logic [3:0] exp_rd;
        bit fs;
        bit app_next;
        @(posedge clk);
        #1;
        bus.i_hs = hs; bus.i_vs = vs; bus.i_de = de; bus.cfg_update = upd;
        drive_pins();
        fs = vs && !m_vs_prev;
        m_vs_prev = vs;
        if (fs) xy_valid = 1;
        exp_rd = '0;
        e.de = de; e.hs = hs; e.vs = vs; e.sel = 4; e.alpha = BG;
        e.x = col; e.y = row; e.xy = xy_valid; e.border = 0;
        if (de) begin
            for (int i = 0; i < 4; i++) begin
                if (win(i, col, row)) begin
                    exp_rd[i] = 1'b1;
                    e.sel = i; e.alpha = sh_a[i]; e.border = edge_of(i, col, row);
                end
            end
        end
`ifdef LAYER_BORDER_EN
        if (e.border) e.alpha = 255;
`endif
        app_next = fs && (m_pend || upd);
        if (app_next) begin
            for (int i = 0; i < 4; i++) begin
                sh_en[i] = cfg_en[i]; sh_top[i] = cfg_top[i]; sh_left[i] = cfg_left[i];
                sh_w[i] = cfg_w[i]; sh_h[i] = cfg_h[i]; sh_a[i] = cfg_a[i];
            end
            m_pend = 0;
        end else if (upd) begin
            m_pend = 1;
        end
        @(negedge clk);
        n_checks++;
        if (bus.layer_rdreq !== exp_rd) begin
            n_fail++;
            $display("FAIL rdreq x=%0d y=%0d: got %b expected %b", col, row, bus.layer_rdreq, exp_rd);
        end
        n_checks++;
        if (bus.cfg_applied !== m_app_now) begin
            n_fail++;
            $display("FAIL cfg_applied x=%0d y=%0d: got %b expected %b", col, row, bus.cfg_applied, m_app_now);
        end
        m_app_now = app_next;
        for (int i = 0; i < 4; i++) if (bus.layer_rdreq[i] === 1'b1) rd_cnt[i]++;
        if (bus.layer_rdreq[0] === 1'b1 && first_col < 0) first_col = col;
        if (bus.cfg_applied === 1'b1) app_cnt++;
        if (de && col == 150 && row == 150) obs_rd_a = bus.layer_rdreq;
        exp_q.push_back(e);
        if (exp_q.size() > 2) begin
            h = exp_q.pop_front();
            n_checks++;
            if ({bus.o_hs, bus.o_vs, bus.o_de} !== {h.hs, h.vs, h.de}) begin
                n_fail++;
                $display("FAIL sync x=%0d y=%0d: got hs/vs/de %b%b%b expected %b%b%b",
                         h.x, h.y, bus.o_hs, bus.o_vs, bus.o_de, h.hs, h.vs, h.de);
            end
            n_checks++;
            if (bus.o_sel !== 3'(h.sel) || bus.o_alpha !== 8'(h.alpha)) begin
                n_fail++;
                $display("FAIL pixel x=%0d y=%0d: got sel=%0d alpha=%h expected sel=%0d alpha=%h",
                         h.x, h.y, bus.o_sel, bus.o_alpha, h.sel, h.alpha);
            end
            if (h.de && h.xy) begin
                n_checks++;
                if (bus.o_x !== 12'(h.x) || bus.o_y !== 12'(h.y)) begin
                    n_fail++;
                    $display("FAIL position: got x=%0d y=%0d expected x=%0d y=%0d",
                             bus.o_x, bus.o_y, h.x, h.y);
                end
            end
`ifdef LAYER_BORDER_EN
            n_checks++;
            if (bus.o_border !== h.border) begin
                n_fail++;
                $display("FAIL border x=%0d y=%0d: got %b expected %b", h.x, h.y, bus.o_border, h.border);
            end
`endif
            if (bus.o_de === 1'b1 && bus.o_sel <= 3'd4) sel_cnt[int'(bus.o_sel)]++;
            if (h.de && h.x == 150 && h.y == 150) begin
                obs_sel_a = bus.o_sel; obs_alpha_a = bus.o_alpha;
            end
            if (h.de && h.x == 50 && h.y == 50) obs_sel_b = bus.o_sel;
        end
    endtask

    // upd_row: -2 none, -1 on the vs edge cycle, r>=0 at the start of active row r
    // (optionally moving layer 0's left edge at the same moment).
    task automatic run_frame(input int h_act, input int v_act,
                             input int upd_row, input int new_left0);
        bit upd;
        clear_counts();
        for (int l = 0; l < v_act + 2; l++) begin
            for (int c = 0; c < h_act + 4; c++) begin
                upd = 0;
                if (upd_row == -1 && l == 0 && c == 0) upd = 1;
                if (upd_row >= 0 && l == upd_row + 2 && c == 0) begin
                    upd = 1;
                    if (new_left0 >= 0) cfg_left[0] = new_left0;
                end
                drive_cycle(c == h_act + 1 || c == h_act + 2, l == 0,
                            l >= 2 && c < h_act, c, l - 2, upd);
            end
        end
        drive_cycle(0, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 0);
        $display("frame %0dx%0d: rdreq %0d/%0d/%0d/%0d applied=%0d first_col=%0d",
                 h_act, v_act, rd_cnt[0], rd_cnt[1], rd_cnt[2], rd_cnt[3], app_cnt, first_col);
    endtask

    task automatic pulse_update();
        drive_cycle(0, 0, 0, 0, 0, 1);
    endtask

    task automatic zero_inputs();
        bus.i_hs = 0; bus.i_vs = 0; bus.i_de = 0; bus.cfg_update = 0;
    endtask

    task automatic release_reset();
        zero_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        zero_inputs();
        clear_cfg();
        drive_pins();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.o_sel !== 3'd4) begin n_fail++; $display("FAIL reset o_sel: got %0d expected 4", bus.o_sel); end
        n_checks++;
        if (bus.o_alpha !== BG) begin n_fail++; $display("FAIL reset o_alpha: got %h expected %h", bus.o_alpha, BG); end
        n_checks++;
        if ({bus.o_hs, bus.o_vs, bus.o_de, bus.cfg_applied} !== 4'b0000) begin
            n_fail++; $display("FAIL reset flags: got %b expected 0000", {bus.o_hs, bus.o_vs, bus.o_de, bus.cfg_applied});
        end
        n_checks++;
        if (bus.o_x !== 12'd0 || bus.o_y !== 12'd0) begin
            n_fail++; $display("FAIL reset position: got %0d,%0d expected 0,0", bus.o_x, bus.o_y);
        end
        n_checks++;
        if (bus.layer_rdreq !== 4'b0000) begin n_fail++; $display("FAIL reset rdreq: got %b expected 0000", bus.layer_rdreq); end
        release_reset();
        $display("reset released");
    endtask

    task automatic test_idle();
        run_frame(640, 4, -2, -1);
        n_checks++;
        if (rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3] != 0) begin
            n_fail++; $display("FAIL idle rdreq count: got %0d expected 0", rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3]);
        end
        n_checks++;
        if (sel_cnt[4] != 2560) begin n_fail++; $display("FAIL idle background count: got %0d expected 2560", sel_cnt[4]); end
        n_checks++;
        if (app_cnt != 0) begin n_fail++; $display("FAIL idle applied count: got %0d expected 0", app_cnt); end
    endtask

    task automatic test_layer0();
        clear_cfg();
        set_layer(0, 10, 20, 100, 50, 8'h80);
        pulse_update();
        run_frame(124, 62, -2, -1);
        n_checks++;
        if (rd_cnt[0] != 5000) begin n_fail++; $display("FAIL layer0 rdreq count: got %0d expected 5000", rd_cnt[0]); end
        n_checks++;
        if (rd_cnt[1] + rd_cnt[2] + rd_cnt[3] != 0) begin
            n_fail++; $display("FAIL layer0 other rdreq: got %0d expected 0", rd_cnt[1] + rd_cnt[2] + rd_cnt[3]);
        end
        n_checks++;
        if (sel_cnt[0] != 5000) begin n_fail++; $display("FAIL layer0 sel count: got %0d expected 5000", sel_cnt[0]); end
        n_checks++;
        if (first_col != 20) begin n_fail++; $display("FAIL layer0 first column: got %0d expected 20", first_col); end
        n_checks++;
        if (app_cnt != 1) begin n_fail++; $display("FAIL layer0 applied count: got %0d expected 1", app_cnt); end
    endtask

    task automatic test_overlap();
        clear_cfg();
        set_layer(0, 0, 0, 320, 240, 8'h11);
        set_layer(3, 100, 100, 320, 240, 8'hC3);
        obs_rd_a = 4'hx; obs_sel_a = 3'hx; obs_sel_b = 3'hx; obs_alpha_a = 8'hxx;
        pulse_update();
        run_frame(152, 152, -2, -1);
        n_checks++;
        if (obs_rd_a !== 4'b1001) begin n_fail++; $display("FAIL overlap rdreq at 150,150: got %b expected 1001", obs_rd_a); end
        n_checks++;
        if (obs_sel_a !== 3'd3 || obs_alpha_a !== 8'hC3) begin
            n_fail++; $display("FAIL overlap top at 150,150: got sel=%0d alpha=%h expected sel=3 alpha=c3", obs_sel_a, obs_alpha_a);
        end
        n_checks++;
        if (obs_sel_b !== 3'd0) begin n_fail++; $display("FAIL overlap sel at 50,50: got %0d expected 0", obs_sel_b); end
        n_checks++;
        if (rd_cnt[0] != 23104 || rd_cnt[3] != 2704) begin
            n_fail++; $display("FAIL overlap rdreq counts: got %0d/%0d expected 23104/2704", rd_cnt[0], rd_cnt[3]);
        end
        n_checks++;
        if (sel_cnt[0] != 20400 || sel_cnt[3] != 2704) begin
            n_fail++; $display("FAIL overlap sel counts: got %0d/%0d expected 20400/2704", sel_cnt[0], sel_cnt[3]);
        end
    endtask

    task automatic test_mid_frame_update();
        clear_cfg();
        set_layer(0, 4, 8, 16, 8, 8'h40);
        pulse_update();
        run_frame(64, 32, -2, -1);
        n_checks++;
        if (rd_cnt[0] != 128 || app_cnt != 1) begin
            n_fail++; $display("FAIL mid base frame: got rdreq=%0d applied=%0d expected 128/1", rd_cnt[0], app_cnt);
        end
        run_frame(64, 32, 10, 30);
        n_checks++;
        if (first_col != 8 || rd_cnt[0] != 128) begin
            n_fail++; $display("FAIL mid current frame: got first_col=%0d rdreq=%0d expected 8/128", first_col, rd_cnt[0]);
        end
        n_checks++;
        if (app_cnt != 0) begin n_fail++; $display("FAIL mid early apply: got %0d expected 0", app_cnt); end
        run_frame(64, 32, -2, -1);
        n_checks++;
        if (app_cnt != 1 || first_col != 30) begin
            n_fail++; $display("FAIL mid next frame: got applied=%0d first_col=%0d expected 1/30", app_cnt, first_col);
        end
        cfg_left[0] = 40;
        run_frame(64, 32, -1, -1);
        n_checks++;
        if (app_cnt != 1 || first_col != 40) begin
            n_fail++; $display("FAIL coincident update: got applied=%0d first_col=%0d expected 1/40", app_cnt, first_col);
        end
        run_frame(64, 32, -2, -1);
        n_checks++;
        if (app_cnt != 0 || first_col != 40) begin
            n_fail++; $display("FAIL coincident leftover pending: got applied=%0d first_col=%0d expected 0/40", app_cnt, first_col);
        end
    endtask

    task automatic test_boundary();
        clear_cfg();
        set_layer(0, 0, 4000, 200, 1, 8'h77);
        set_layer(1, 0, 10, 0, 2, 8'h22);
        pulse_update();
        run_frame(4096, 2, -2, -1);
        n_checks++;
        if (rd_cnt[0] != 96 || first_col != 4000) begin
            n_fail++; $display("FAIL boundary right edge: got rdreq=%0d first_col=%0d expected 96/4000", rd_cnt[0], first_col);
        end
        n_checks++;
        if (rd_cnt[1] != 0) begin n_fail++; $display("FAIL boundary zero width: got %0d expected 0", rd_cnt[1]); end
    endtask

    task automatic test_reset_mid();
        clear_cfg();
        set_layer(0, 0, 0, 64, 32, 8'h99);
        pulse_update();
        clear_counts();
        for (int l = 0; l < 6; l++) begin
            for (int c = 0; c < 68; c++) begin
                if (l == 5 && c == 20) break;
                drive_cycle(c == 65 || c == 66, l == 0, l >= 2 && c < 64, c, l - 2, 0);
            end
        end
        n_checks++;
        if (rd_cnt[0] != 212) begin n_fail++; $display("FAIL reset-mid pre count: got %0d expected 212", rd_cnt[0]); end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.layer_rdreq !== 4'b0000) begin n_fail++; $display("FAIL async reset rdreq: got %b expected 0000", bus.layer_rdreq); end
        n_checks++;
        if (bus.o_de !== 1'b0 || bus.o_sel !== 3'd4 || bus.o_alpha !== BG) begin
            n_fail++; $display("FAIL async reset outputs: got de=%b sel=%0d alpha=%h expected 0/4/%h", bus.o_de, bus.o_sel, bus.o_alpha, BG);
        end
        n_checks++;
        if (bus.o_x !== 12'd0 || bus.cfg_applied !== 1'b0) begin
            n_fail++; $display("FAIL async reset x/applied: got %0d/%b expected 0/0", bus.o_x, bus.cfg_applied);
        end
        release_reset();
        clear_counts();
        for (int l = 5; l < 34; l++) begin
            for (int c = (l == 5) ? 20 : 0; c < 68; c++) begin
                drive_cycle(c == 65 || c == 66, 1'b0, c < 64, c, l - 2, 0);
            end
        end
        n_checks++;
        if (rd_cnt[0] != 0) begin n_fail++; $display("FAIL reset-mid rest of frame: got %0d expected 0", rd_cnt[0]); end
        run_frame(64, 32, -2, -1);
        n_checks++;
        if (rd_cnt[0] != 0 || app_cnt != 0) begin
            n_fail++; $display("FAIL reset-mid no update frame: got rdreq=%0d applied=%0d expected 0/0", rd_cnt[0], app_cnt);
        end
        pulse_update();
        run_frame(64, 32, -2, -1);
        n_checks++;
        if (rd_cnt[0] != 2048 || app_cnt != 1) begin
            n_fail++; $display("FAIL reset-mid recovery: got rdreq=%0d applied=%0d expected 2048/1", rd_cnt[0], app_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_layer0();
        test_overlap();
        test_mid_frame_update();
        test_boundary();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end
endmodule
